// File: rtl/usb_host_pkg.sv
// Shared types for the USB host transaction scheduler: FSM encoding,
// default descriptor field widths and the latched transfer descriptor.
package usb_host_pkg;

    localparam int USB_ADDR_W = 7;
    localparam int USB_ENDP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT     = 3'd2,
        S_GAP      = 3'd3,
        S_COMPLETE = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic                  rw;
        logic [USB_ADDR_W-1:0] addr;
        logic [USB_ENDP_W-1:0] endp;
    } txn_desc_t;

endpackage

// File: rtl/usb_txn_scheduler_if.sv
// Requester-side and engine-side signals of the scheduler; master is the
// scheduler's view, slave is the requesters/engine view.
interface usb_txn_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 7,
    parameter int ENDP_W = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_rw;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*ENDP_W-1:0] req_endp;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    ok;
    logic                    eng_start;
    logic                    eng_rw;
    logic [ADDR_W-1:0]       eng_addr;
    logic [ENDP_W-1:0]       eng_endp;
    logic                    eng_abort;
    logic                    eng_done;
    logic                    eng_success;
    logic                    busy;
    logic                    timeout_err;

    modport master (
        input  req, req_rw, req_addr, req_endp, eng_done, eng_success,
        output gnt, done, ok, eng_start, eng_rw, eng_addr, eng_endp,
               eng_abort, busy, timeout_err
    );

    modport slave (
        output req, req_rw, req_addr, req_endp, eng_done, eng_success,
        input  gnt, done, ok, eng_start, eng_rw, eng_addr, eng_endp,
               eng_abort, busy, timeout_err
    );
endinterface

// File: rtl/usb_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    logic found;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand     = (i + 32'(ptr)) % N_REQ;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_txn_scheduler.sv
// Shares one USB host protocol engine between N_REQ requesters with
// round-robin arbitration, bounded retries with back-off and a watchdog.
module usb_txn_scheduler
    import usb_host_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = USB_ADDR_W,
    parameter int ENDP_W    = USB_ENDP_W,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 16,
    parameter int TIMEOUT   = 4096
) (
    input logic               clk,
    input logic               rst,
    usb_txn_scheduler_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    txn_desc_t        desc_q, desc_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             ok_q, ok_d;
    logic             start_q, start_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [ENDP_W-1:0] endp_a [N_REQ];
    logic             expire;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_a[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign endp_a[g] = bus.req_endp[g*ENDP_W +: ENDP_W];
    end

    // Abort must see eng_done in the expiry cycle itself, so it is decoded, not registered.
    assign expire = (state_q == S_WAIT) && (timer_q == TIMER_LAST) && !bus.eng_done;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
        retry_d = retry_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ok_d    = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d     = S_LAUNCH;
                    idx_d       = arb_idx;
                    gnt_d       = arb_gnt;
                    desc_d.rw   = bus.req_rw[arb_idx];
                    desc_d.addr = USB_ADDR_W'(addr_a[arb_idx]);
                    desc_d.endp = USB_ENDP_W'(endp_a[arb_idx]);
                    retry_d     = '0;
                    start_d     = 1'b1;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    if (bus.eng_success) begin
                        state_d = S_COMPLETE;
                        done_d  = gnt_q;
                        ok_d    = 1'b1;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        state_d = S_GAP;
                        retry_d = retry_q + 1'b1;
                        gap_d   = GW'(RETRY_GAP);
                    end else begin
                        state_d = S_COMPLETE;
                        done_d  = gnt_q;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_COMPLETE;
                    done_d  = gnt_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GW'(1)) begin
                    state_d = S_LAUNCH;
                    start_d = 1'b1;
                end
            end
            S_COMPLETE: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            desc_q  <= '0;
            retry_q <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ok_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            start_q <= start_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.ok          = ok_q;
    assign bus.eng_start   = start_q;
    assign bus.eng_rw      = desc_q.rw;
    assign bus.eng_addr    = ADDR_W'(desc_q.addr);
    assign bus.eng_endp    = ENDP_W'(desc_q.endp);
    assign bus.eng_abort   = expire;
    assign bus.timeout_err = expire;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: doc/usb_txn_scheduler.md
Name: usb_txn_scheduler

Overview:
- Shares the single USB host protocol engine (token/data/handshake sequencer) between N_REQ requesters.
- Arbitrates round-robin, latches the winner's transfer descriptor and launches the engine with a one-cycle start.
- Waits for the engine's system-done and retries failed transactions up to MAX_RETRY times after a back-off gap.
- Enforces a watchdog timeout and reports per-requester completion with a pass/fail status.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 7, USB device address width.
- ENDP_W, 4, endpoint number width.
- MAX_RETRY, 3, re-launches allowed after the first failed attempt.
- RETRY_GAP, 16, idle cycles between a failed attempt and the re-launch (≥1).
- TIMEOUT, 4096, cycles allowed from launch to eng_done before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request level.
- req_rw  in  N_REQ  per-requester direction, 1=write, 0=read.
- req_addr  in  N_REQ*ADDR_W  packed device addresses; requester i occupies slice i.
- req_endp  in  N_REQ*ENDP_W  packed endpoint numbers; requester i occupies slice i.
- gnt  out  N_REQ  one-hot, owner of the engine.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- ok  out  1  valid with done: 1=success, 0=failed or timed out.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_rw  out  1  latched direction.
- eng_addr  out  ADDR_W  latched device address.
- eng_endp  out  ENDP_W  latched endpoint number.
- eng_abort  out  1  one-cycle pulse that returns the engine to idle.
- eng_done  in  1  engine system-done pulse.
- eng_success  in  1  engine process-success, sampled with eng_done.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset:
  - State goes to IDLE; rr pointer, retry count and timer clear to 0.
  - Every output is 0, including the eng_* descriptor registers.
  - Reset mid-transaction drops the transfer silently: no done pulse. The engine is reset externally.
- FSM states: IDLE, LAUNCH, WAIT, GAP, COMPLETE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from ptr, wrapping modulo N_REQ.
  - Register idx, eng_rw, eng_addr and eng_endp. Clear the retry count. Go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH:
  - eng_start=1 for exactly this cycle. Clear the timer. Go to WAIT.
  - Latency: req first seen high in cycle t gives eng_start in cycle t+1.
- WAIT: the timer increments every cycle.
  - eng_done with eng_success=1: go to COMPLETE, ok=1.
  - eng_done with eng_success=0 and retry count < MAX_RETRY: increment the retry count, load the gap counter with RETRY_GAP, go to GAP.
  - eng_done with eng_success=0 and retry count = MAX_RETRY: go to COMPLETE, ok=0.
  - Timer reaches TIMEOUT-1 with no eng_done: eng_abort=1 and timeout_err=1 in that cycle, go to COMPLETE, ok=0. Timeouts are never retried.
  - eng_done in the same cycle as timer expiry: eng_done wins, with no abort and no timeout_err.
- GAP:
  - Decrement the gap counter. Go to LAUNCH when it reaches 1, so there are exactly RETRY_GAP GAP cycles.
  - Any eng_done seen in GAP is ignored.
- COMPLETE:
  - done[idx]=1 for one cycle, with ok valid in the same cycle.
  - ptr <= (idx+1) mod N_REQ. Go to IDLE.
- gnt[idx] is high from LAUNCH through COMPLETE inclusive; gnt is 0 in IDLE.
- Requesters hold req, req_rw, req_addr and req_endp stable until done. Dropping req mid-transfer does not cancel it; the transfer runs to COMPLETE.
- A requester holding req after its done is re-arbitrated in the next IDLE. Round-robin gives every other pending requester priority first.
- Attempts per transaction never exceed 1+MAX_RETRY.
- Counter widths: timer is $clog2(TIMEOUT) bits, retry count is $clog2(MAX_RETRY+1) bits, gap counter is $clog2(RETRY_GAP+1) bits. No counter wraps, because each is bounded by its state exit.
- Descriptor registers hold their value from IDLE selection until the next selection, including across retries.

Decomposition:
- Package usb_host_pkg holds:
  - the sched_state_e enum (logic [2:0]);
  - the ADDR_W and ENDP_W defaults;
  - a txn_desc_t struct {rw, addr, endp}.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: req[N_REQ] and ptr.
  - Outputs: a one-hot grant and a binary index.
  - Instantiated once and used only in IDLE.

Test Plan:
- req=4'b0001 (rw=1, addr=7'h05, endp=4'h1), engine returns eng_done+eng_success 20 cycles after start -> eng_start in cycle 1; eng_rw=1, eng_addr=05, eng_endp=1; done[0]=1, ok=1; gnt[0] high throughout.
- req=4'b1111 held continuously, every transaction succeeds -> grants run in order 0,1,2,3,0; never two gnt bits high at once.
- Requester 2 transfer where the engine fails 3 times then succeeds -> 4 eng_start pulses, each pair separated by exactly 16 GAP cycles; done[2] with ok=1.
- Engine fails on every attempt -> exactly 4 eng_start pulses, then done with ok=0; no timeout_err.
- Engine never returns eng_done -> eng_abort and timeout_err in cycle launch+4096, done with ok=0. A second run drives eng_done in that same expiry cycle -> no abort and no timeout_err.
- Assert rst during WAIT -> all outputs 0 in the same cycle, no done pulse. After release, a pending req=4'b0100 is granted starting from ptr=0.
